// File: rtl/line_track_ctrl.sv
// line_track_ctrl: synchronises and debounces the three line sensors and runs the tracking FSM.
// The motor mode and lost flag are registered from the next state, so they change in step with the state.
module line_track_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LOST_TIMEOUT    = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] sensor_raw,
  output logic [1:0] mode,
  output logic       lost,
  output logic [2:0] sensor_deb
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 3);
  localparam int LW = $clog2(LOST_TIMEOUT + 1);
  localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [LW-1:0] LMAX = LW'(LOST_TIMEOUT - 1);
  typedef enum logic [2:0] {S_STOP, S_FWD, S_TL, S_TR, S_SRCH} state_t;
  logic [2:0]    r_s1, r_s2, r_prev;
  logic [CW-1:0] r_cnt, w_stab;
  logic [LW-1:0] r_lcnt, w_lcnt;
  state_t        r_state, w_nxt, w_dir_st;
  logic          r_lt, w_lt, w_fwd, w_left, w_right, w_none, w_dir;
  logic [1:0]    w_mode;
  // Cycles sensor_s has held its current value, including the present one.
  assign w_stab   = (r_s2 != r_prev) ? CW'(1) : r_cnt + CW'(2);
  assign w_fwd    = sensor_deb == 3'b010 || sensor_deb == 3'b111;
  assign w_left   = sensor_deb == 3'b100 || sensor_deb == 3'b110;
  assign w_right  = sensor_deb == 3'b001 || sensor_deb == 3'b011;
  assign w_none   = sensor_deb == 3'b000;
  assign w_dir    = w_fwd | w_left | w_right;
  assign w_dir_st = w_fwd ? S_FWD : w_left ? S_TL : S_TR;
  always_comb begin
    w_nxt  = r_state;
    w_lcnt = '0;
    if (!en)
      w_nxt = S_STOP;
    else if (w_dir)
      w_nxt = w_dir_st;
    else if (r_state == S_SRCH) begin
      w_nxt  = (r_lcnt == LMAX) ? S_STOP : S_SRCH;
      w_lcnt = (r_lcnt == LMAX) ? '0 : r_lcnt + 1'b1;
    end
    else if (w_none && r_state != S_STOP)
      w_nxt = S_SRCH;
  end
  assign w_lt   = (w_nxt == S_TL) ? 1'b0 : (w_nxt == S_TR) ? 1'b1 : r_lt;
  assign w_mode = (w_nxt == S_STOP) ? 2'b00 :
                  (w_nxt == S_FWD)  ? 2'b01 :
                  (w_nxt == S_TL)   ? 2'b10 :
                  (w_nxt == S_TR)   ? 2'b11 : {1'b1, w_lt};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_prev     <= '0;
      r_cnt      <= '0;
      sensor_deb <= '0;
      r_state    <= S_STOP;
      r_lt       <= 1'b0;
      r_lcnt     <= '0;
      mode       <= 2'b00;
      lost       <= 1'b0;
    end else begin
      r_s1       <= sensor_raw;
      r_s2       <= r_s1;
      r_prev     <= r_s2;
      r_cnt      <= (r_s2 != r_prev) ? '0 : (r_cnt == DMAX) ? r_cnt : r_cnt + 1'b1;
      sensor_deb <= (w_stab >= DMAX) ? r_s2 : sensor_deb;
      r_state    <= w_nxt;
      r_lt       <= w_lt;
      r_lcnt     <= w_lcnt;
      mode       <= w_mode;
      lost       <= w_nxt == S_SRCH;
    end
  end
endmodule

// File: tb/tb_line_track_ctrl.sv
// tb_line_track_ctrl: directed steps with a due-cycle scoreboard for line_track_ctrl.
module tb_line_track_ctrl;
  logic       clk = 0, rst = 1, en = 0;
  logic [2:0] raw = 3'b000;
  logic [1:0] mode;
  logic       lost;
  logic [2:0] deb;
  int         cyc = 0, nvec = 0, nmis = 0;
  typedef struct {int due; logic [5:0] v; string tag;} exp_t;
  exp_t q[$];

  line_track_ctrl #(.DEBOUNCE_CYCLES(4), .LOST_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .sensor_raw(raw),
    .mode(mode), .lost(lost), .sensor_deb(deb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Entries fall due a fixed number of edges after the stimulus that produced them.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due == cyc) begin
        nvec++;
        assert ({mode, lost, deb} === q[i].v)
        else begin
          nmis++;
          $error("FAIL %s: {mode,lost,deb} got %b expected %b", q[i].tag, {mode, lost, deb}, q[i].v);
        end
        q.delete(i);
      end
  end

  task automatic push(input int d, input logic [1:0] m, input logic l, input logic [2:0] s, input string tag);
    q.push_back('{cyc + d, {m, l, s}, tag});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_now(input logic [5:0] e, input string tag);
    nvec++;
    assert ({mode, lost, deb} === e)
    else begin
      nmis++;
      $error("FAIL %s: {mode,lost,deb} got %b expected %b", tag, {mode, lost, deb}, e);
    end
  endtask

  initial begin
    step(2);
    #1 chk_now(6'b00_0_000, "reset_state");
    rst = 0;
    // reach TURN_R, then reset mid-turn
    step(1); en = 1; raw = 3'b001;
    push(6, 2'b00, 0, 3'b001, "tr_deb_before_mode");
    push(7, 2'b11, 0, 3'b001, "tr_enter");
    step(9);
    rst = 1;
    #1 chk_now(6'b00_0_000, "rst_mid_turn");
    step(1); rst = 0; raw = 3'b010;
    push(5, 2'b00, 0, 3'b000, "post_rst_deb_latency");
    push(6, 2'b00, 0, 3'b010, "post_rst_mode_latency");
    push(7, 2'b01, 0, 3'b010, "post_rst_fwd");
    step(9);
    // 3-cycle glitch must be filtered
    raw = 3'b100;
    push(3, 2'b01, 0, 3'b010, "glitch_a");
    push(6, 2'b01, 0, 3'b010, "glitch_b");
    push(9, 2'b01, 0, 3'b010, "glitch_c");
    push(12, 2'b01, 0, 3'b010, "glitch_d");
    step(3); raw = 3'b010;
    step(10);
    // turns and hold pattern
    raw = 3'b110;
    push(6, 2'b01, 0, 3'b110, "left_deb");
    push(7, 2'b10, 0, 3'b110, "left_mode");
    step(9); raw = 3'b011;
    push(7, 2'b11, 0, 3'b011, "right_mode");
    step(9); raw = 3'b101;
    push(7, 2'b11, 0, 3'b101, "hold_a");
    push(10, 2'b11, 0, 3'b101, "hold_b");
    step(11);
    // line lost from TURN_R: 8 cycles of search then stop
    raw = 3'b000;
    push(6, 2'b11, 0, 3'b000, "lost_deb");
    push(7, 2'b11, 1, 3'b000, "search_first");
    push(14, 2'b11, 1, 3'b000, "search_last");
    push(15, 2'b00, 0, 3'b000, "search_timeout");
    step(17); raw = 3'b010;
    push(7, 2'b01, 0, 3'b010, "recover_fwd");
    step(9);
    // recover from SEARCH at lost_cnt=5, then full timeout again
    raw = 3'b001;
    push(7, 2'b11, 0, 3'b001, "tr_again");
    step(9); raw = 3'b000;
    push(7, 2'b11, 1, 3'b000, "search2_start");
    push(12, 2'b11, 1, 3'b001, "search2_cnt5");
    push(13, 2'b11, 0, 3'b001, "search2_exit_tr");
    step(6); raw = 3'b001;
    step(10); raw = 3'b000;
    push(7, 2'b11, 1, 3'b000, "search3_start");
    push(14, 2'b11, 1, 3'b000, "search3_last");
    push(15, 2'b00, 0, 3'b000, "search3_timeout");
    step(17);
    // en drop in SEARCH, re-enable with no line
    raw = 3'b110;
    push(7, 2'b10, 0, 3'b110, "tl_enter");
    step(9); raw = 3'b000;
    push(7, 2'b10, 1, 3'b000, "search_left");
    step(9); en = 0;
    push(1, 2'b00, 0, 3'b000, "en_drop");
    step(2); en = 1;
    push(1, 2'b00, 0, 3'b000, "en_back_stop");
    push(5, 2'b00, 0, 3'b000, "en_back_stay");
    step(7);
    // last_turn survives STOP: FORWARD then lost searches left
    raw = 3'b010;
    push(7, 2'b01, 0, 3'b010, "fwd_after_stop");
    step(9); raw = 3'b000;
    push(7, 2'b10, 1, 3'b000, "search_keeps_left");
    step(9);
    for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
    if (q.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain: %0d scoreboard entries never fell due, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
